mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 161 ++++++++++++++++
 tb/tb_mem_responder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//   Single-port memory slave with a fixed number of wait states per access.
//   An initiator raises readMem or writeMem. The request is accepted in IDLE,
//   and the responder then walks WAIT -> ACCESS -> DONE. The memory is written,
//   or rdata is loaded, on the ACCESS->DONE edge. rdyMem pulses for one cycle
//   right after DONE.
//
//   Optional feature: define MEM_RESPONDER_PARITY_EN to store one even-parity
//   bit per word and flag a parity mismatch on reads through parErr.
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   readMem   in   read request, level-sensitive
//   writeMem  in   write request, level-sensitive (wins over readMem)
//   addr      in   word address, sampled on acceptance
//   wdata     in   write data, sampled on acceptance
//   rdata     out  registered read data, holds until the next read completes
//   rdyMem    out  one-cycle completion strobe
//   busy      out  high while an accepted access is outstanding
//   parErr    out  (MEM_RESPONDER_PARITY_EN only) parity error, aligned to rdyMem
// -----------------------------------------------------------------------------
module mem_responder #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              readMem,
  input  logic              writeMem,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rdyMem,
  output logic              busy
`ifdef MEM_RESPONDER_PARITY_EN
  ,
  output logic              parErr
`endif
);

  localparam int         DEPTH   = 1 << ADDR_W;
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYC);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_cnt;
  logic [3:0]          w_cnt_dec;
  logic                w_accept;
  logic                w_wait_done;
  logic                w_complete;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_is_wr;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [DATA_W-1:0]   r_rdata;
  logic                r_rdy;

  // Saturating decrement. Leaving WAIT when the decremented value hits zero
  // makes WAIT last max(WAIT_CYC,1) cycles.
  assign w_cnt_dec = (r_cnt == 4'd0) ? 4'd0 : r_cnt - 4'd1;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (readMem || writeMem) w_next = S_WAIT;
      S_WAIT:   if (w_cnt_dec == 4'd0)   w_next = S_ACCESS;
      S_ACCESS: w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    w_accept    = (r_state == S_IDLE) && (readMem || writeMem);
    w_wait_done = (r_state == S_WAIT) && (w_cnt_dec == 4'd0);
    w_complete  = (r_state == S_ACCESS);
    busy        = (r_state != S_IDLE);
  end

  // Wait counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          r_cnt <= 4'd0;
    else if (w_accept)                r_cnt <= WAIT_LD;
    else if (r_state == S_WAIT)       r_cnt <= w_cnt_dec;
  end

  // Request capture; addr/wdata changes while busy are not seen
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr  <= addr;
      r_wdata <= wdata;
      r_is_wr <= writeMem;
    end
  end

  // Memory array, cleared by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_complete && r_is_wr) begin
      r_mem[r_addr] <= r_wdata;
    end
  end

  // Read data and completion strobe. rdyMem follows DONE by one cycle, so a
  // reset at any point before then suppresses the pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
      r_rdy   <= 1'b0;
    end else begin
      if (w_complete && !r_is_wr) r_rdata <= r_mem[r_addr];
      r_rdy <= (r_state == S_DONE);
    end
  end

  assign rdata  = r_rdata;
  assign rdyMem = r_rdy;

`ifdef MEM_RESPONDER_PARITY_EN
  logic r_par [DEPTH];
  logic r_par_err;

  // Parity bit per word, written alongside the data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_par[i] <= 1'b0;
    end else if (w_complete && r_is_wr) begin
      r_par[r_addr] <= ^r_wdata;
    end
  end

  // Checked in DONE so the flag lines up with rdyMem
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_par_err <= 1'b0;
    else     r_par_err <= (r_state == S_DONE) && !r_is_wr &&
                          ((^r_mem[r_addr]) != r_par[r_addr]);
  end

  assign parErr = r_par_err;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
//   Self-checking bench for mem_responder (DATA_W=8, ADDR_W=4, WAIT_CYC=2).
//   A behavioural memory model produces the expected rdata of each access,
//   which is queued when the request is driven and compared when rdyMem fires.
// -----------------------------------------------------------------------------
module tb_mem_responder;

  localparam int TB_WAIT   = 2;
  localparam int EXP_EDGES = ((TB_WAIT > 0) ? TB_WAIT : 1) + 2;
  localparam int BUDGET    = 40;

  logic       clk;
  logic       rst;
  logic       readMem;
  logic       writeMem;
  logic [3:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       rdyMem;
  logic       busy;
`ifdef MEM_RESPONDER_PARITY_EN
  logic       parErr;
  logic       last_perr;
`endif

  int         n_checks;
  int         n_fail;
  logic [7:0] model [16];
  logic [7:0] model_rdata;
  logic [7:0] exp_q [$];

  mem_responder #(
    .DATA_W  (8),
    .ADDR_W  (4),
    .WAIT_CYC(TB_WAIT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .readMem (readMem),
    .writeMem(writeMem),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .rdyMem  (rdyMem),
    .busy    (busy)
`ifdef MEM_RESPONDER_PARITY_EN
    ,
    .parErr  (parErr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, time=%0t", $time);
    $fatal(1, "timeout");
  end

  task automatic model_clear();
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    model_rdata = 8'h00;
  endtask

  // One complete access. Entered just after a negedge; returns just after a
  // negedge. With hold=0 the request drops and addr/wdata are scrambled right
  // after acceptance; with hold=1 the request stays up until rdyMem is seen.
  task automatic access(input logic wr, input logic rd, input logic [3:0] a,
                        input logic [7:0] d, input bit hold);
    int         cyc;
    logic [7:0] exp;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_before_req: got %b want 0", busy);
    end
    writeMem = wr;
    readMem  = rd;
    addr     = a;
    wdata    = d;
    if (wr) model[a] = d;
    else    model_rdata = model[a];
    exp_q.push_back(model_rdata);
    @(posedge clk);
    #1;
    if (!hold) begin
      readMem  = 1'b0;
      writeMem = 1'b0;
      addr     = ~a;
      wdata    = ~d;
    end
    cyc = 0;
    while (cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        n_checks++;
        if (busy !== 1'b1) begin
          n_fail++;
          $display("FAIL busy_during_access: got %b want 1", busy);
        end
      end
      if (rdyMem === 1'b1) break;
    end
    readMem  = 1'b0;
    writeMem = 1'b0;
`ifdef MEM_RESPONDER_PARITY_EN
    last_perr = parErr;
`endif
    n_checks++;
    if (cyc - 1 != EXP_EDGES) begin
      n_fail++;
      $display("FAIL latency a=%0d wr=%b: got %0d edges want %0d", a, wr, cyc - 1, EXP_EDGES);
    end
    exp = exp_q.pop_front();
    n_checks++;
    if (rdata !== exp) begin
      n_fail++;
      $display("FAIL rdata a=%0d wr=%b: got %h want %h", a, wr, rdata, exp);
    end
    @(negedge clk);
    n_checks++;
    if (rdyMem !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_pulse a=%0d: got rdy=%b busy=%b want rdy=0 busy=0", a, rdyMem, busy);
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    readMem  = 1'b0;
    writeMem = 1'b0;
    addr     = 4'h0;
    wdata    = 8'h00;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (rdata !== 8'h00 || rdyMem !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got rdata=%h rdy=%b busy=%b want 00/0/0", rdata, rdyMem, busy);
    end
    rst = 1'b0;
  endtask

  task automatic test_read_after_reset();
    access(1'b0, 1'b1, 4'd3, 8'h00, 1'b1);
  endtask

  task automatic test_write_read();
    access(1'b1, 1'b0, 4'd5, 8'hA5, 1'b1);
    access(1'b0, 1'b1, 4'd5, 8'h00, 1'b1);
    // request dropped right after acceptance must still complete
    access(1'b1, 1'b0, 4'd9, 8'h69, 1'b0);
    access(1'b0, 1'b1, 4'd9, 8'h00, 1'b0);
  endtask

  task automatic test_priority();
    access(1'b1, 1'b1, 4'd2, 8'h3C, 1'b1);
    access(1'b0, 1'b1, 4'd2, 8'h00, 1'b1);
  endtask

  task automatic test_random();
    logic [3:0] a;
    logic [7:0] d;
    for (int i = 0; i < 4; i++) begin
      a = 4'($urandom_range(0, 15));
      d = 8'($urandom_range(1, 255));
      access(1'b1, 1'b0, a, d, 1'b0);
      access(1'b0, 1'b1, a, 8'h00, 1'b0);
    end
  endtask

  task automatic test_reset_mid_access();
    writeMem = 1'b1;
    addr     = 4'd7;
    wdata    = 8'hFF;
    @(posedge clk);
    #1;
    writeMem = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || rdyMem !== 1'b0 || rdata !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset: got busy=%b rdy=%b rdata=%h want 0/0/00", busy, rdyMem, rdata);
    end
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    // first edge after release must accept; a stale pulse would show as bad latency
    access(1'b0, 1'b1, 4'd7, 8'h00, 1'b1);
    access(1'b0, 1'b1, 4'd5, 8'h00, 1'b1);
  endtask

  task automatic test_back_to_back();
    int         cyc;
    int         t_first;
    int         pulses;
    logic [7:0] exp;
    access(1'b1, 1'b0, 4'd1, 8'h5A, 1'b0);
    readMem = 1'b1;
    addr    = 4'd1;
    model_rdata = model[1];
    exp_q.push_back(model_rdata);
    exp_q.push_back(model_rdata);
    cyc     = 0;
    pulses  = 0;
    t_first = 0;
    while (cyc < BUDGET && pulses < 2) begin
      @(negedge clk);
      cyc++;
      if (rdyMem === 1'b1) begin
        pulses++;
        exp = exp_q.pop_front();
        n_checks++;
        if (rdata !== exp) begin
          n_fail++;
          $display("FAIL b2b_rdata pulse=%0d: got %h want %h", pulses, rdata, exp);
        end
        if (pulses == 1) t_first = cyc;
        else begin
          readMem = 1'b0;
          n_checks++;
          if (cyc - t_first != EXP_EDGES + 1) begin
            n_fail++;
            $display("FAIL b2b_gap: got %0d cycles want %0d", cyc - t_first, EXP_EDGES + 1);
          end
        end
      end
    end
    readMem = 1'b0;
    n_checks++;
    if (pulses != 2) begin
      n_fail++;
      $display("FAIL b2b_pulses: got %0d want 2", pulses);
    end
    while (exp_q.size() > 0) void'(exp_q.pop_front());
    // let any in-flight repeat access drain before the next scenario
    repeat (8) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle: got busy=%b want 0", busy);
    end
  endtask

`ifdef MEM_RESPONDER_PARITY_EN
  task automatic test_parity();
    access(1'b0, 1'b1, 4'd5, 8'h00, 1'b1);
    n_checks++;
    if (last_perr !== 1'b0) begin
      n_fail++;
      $display("FAIL parity_clean: got %b want 0", last_perr);
    end
    dut.r_mem[4] = dut.r_mem[4] ^ 8'h01;
    model[4] = model[4] ^ 8'h01;
    access(1'b0, 1'b1, 4'd4, 8'h00, 1'b1);
    n_checks++;
    if (last_perr !== 1'b1) begin
      n_fail++;
      $display("FAIL parity_flip: got %b want 1", last_perr);
    end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_read_after_reset();
    test_write_read();
    test_priority();
    test_random();
    test_back_to_back();
    test_reset_mid_access();
`ifdef MEM_RESPONDER_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
